// File: rtl/add_serial_pkg.sv
// add_serial_pkg: shared sequencer states and default adder latency
package add_serial_pkg;
  localparam int ADD_LAT_DEFAULT = 9;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RELEASE, S_OUT} state_t;
endpackage

// File: rtl/add_serial_lat_cnt.sv
// add_serial_lat_cnt: loadable down-counter with zero flag for serial-op latency
module add_serial_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/add_serial_seq.sv
// add_serial_seq: operand sequencer and result collector for the add_serial bit-serial adder
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = ADD_LAT_DEFAULT,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic             o_add_en,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  input  logic [WIDTH-1:0] i_add_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum
);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(ADD_LAT - 1);
  state_t           r_state, w_next;
  logic             w_load, w_dec, w_zero, w_accept, w_cap;
  logic [WIDTH-1:0] r_add_a, r_add_b, r_res_sum;
  add_serial_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LAT_LD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // unused encodings fall through to the default and recover to idle
  always_comb begin
    w_next = S_IDLE;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      S_IDLE:    w_next = i_in_valid ? S_START : S_IDLE;
      S_START:   begin w_next = S_WAIT; w_load = 1'b1; end
      S_WAIT:    begin w_next = w_zero ? S_RELEASE : S_WAIT; w_dec = !w_zero; end
      S_RELEASE: w_next = S_OUT;
      S_OUT:     w_next = i_res_ready ? S_IDLE : S_OUT;
      default:   w_next = S_IDLE;
    endcase
  end
  assign w_accept = r_state == S_IDLE && i_in_valid;
  assign w_cap    = r_state == S_WAIT && w_zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_res_sum <= '0;
    end else begin
      if (w_accept) begin
        r_add_a <= i_in_a;
        r_add_b <= i_in_b;
      end
      if (w_cap) r_res_sum <= i_add_out;
    end
  assign o_in_ready  = r_state == S_IDLE;
  assign o_add_en    = r_state == S_START || r_state == S_RELEASE;
  assign o_res_valid = r_state == S_OUT;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_res_sum   = r_res_sum;
endmodule

// File: tb/tb_add_serial_seq.sv
// tb_add_serial_seq: directed checks of the sequencer driving a bit-serial adder model
module tb_add_serial_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, res_valid, res_ready = 1'b0, add_en;
  logic [7:0] in_a = '0, in_b = '0, add_a, add_b, add_out, res_sum;
  int         n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, en_cnt = 0, en_viol = 0;
  logic       prev_en = 1'b0;
  logic [7:0] got_q[$], exp_q[$];
  logic [1:0] m_st;
  logic [7:0] m_a, m_b, m_sum;
  logic       m_c;
  logic [2:0] m_n;

  add_serial_seq dut (
    .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .o_add_en(add_en), .o_add_a(add_a), .o_add_b(add_b),
    .i_add_out(add_out), .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_sum(res_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bit-serial adder: load on en, 8 LSB-first bit edges, hold sum in DONE until next en
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_st <= 0; m_a <= 0; m_b <= 0; m_sum <= 0; m_c <= 0; m_n <= 0;
    end else case (m_st)
      2'd0: if (add_en) begin
        m_a <= add_a; m_b <= add_b; m_sum <= 0; m_c <= 0; m_n <= 0; m_st <= 2'd1;
      end
      2'd1: begin
        m_sum <= {m_a[0] ^ m_b[0] ^ m_c, m_sum[7:1]};
        m_c   <= (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));
        m_a   <= m_a >> 1;
        m_b   <= m_b >> 1;
        m_n   <= m_n + 3'd1;
        if (m_n == 3'd7) m_st <= 2'd2;
      end
      default: if (add_en) m_st <= 2'd0;
    endcase
  assign add_out = m_sum;

  always @(negedge clk) begin
    if (add_en) en_cnt <= en_cnt + 1;
    if (add_en && prev_en) en_viol <= en_viol + 1;
    prev_en <= add_en;
    if (res_valid && res_ready) got_q.push_back(res_sum);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && k < 60) begin @(negedge clk); k++; end
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [7:0] exp);
    int k = 0;
    while (!res_valid && k < 60) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, cyc - acc_cyc, 12);
    chk(tag, 32'(res_sum), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int bad, acc0, k, prev, t, en0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_add_en", 32'(add_en), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_add_b", 32'(add_b), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    rst = 1'b0;
    @(negedge clk);

    res_ready = 1'b1;
    send(8'h35, 8'h4A);
    chk("basic_add_a", 32'(add_a), 32'h35);
    chk("basic_add_b", 32'(add_b), 32'h4A);
    wait_res("basic", 8'h7F);

    send(8'hFF, 8'h01); wait_res("wrap_ff01", 8'h00);
    send(8'h80, 8'h80); wait_res("wrap_8080", 8'h00);
    send(8'h00, 8'h00); wait_res("zero", 8'h00);

    res_ready = 1'b0;
    send(8'h5A, 8'h0F);
    k = 0;
    while (!res_valid && k < 60) begin @(negedge clk); k++; end
    chk("bp_lat", cyc - acc_cyc, 12);
    chk("bp_sum", 32'(res_sum), 32'h69);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_sum !== 8'h69 || in_ready) bad++;
    end
    chk("bp_hold", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 1);
    chk("bp_res_valid", 32'(res_valid), 0);

    send(8'h21, 8'h13);
    repeat (4) @(negedge clk);
    acc0 = acc_cyc;
    in_a = 8'h11; in_b = 8'h11; in_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready || add_a !== 8'h21 || add_b !== 8'h13) bad++;
    end
    in_valid = 1'b0;
    chk("busy_drop", bad, 0);
    acc_cyc = acc0;
    wait_res("busy_sum", 8'h34);
    chk("busy_idle", 32'(in_ready), 1);

    send(8'h77, 8'h22);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_res_valid", 32'(res_valid), 0);
    chk("mid_add_en", 32'(add_en), 0);
    chk("mid_add_a", 32'(add_a), 0);
    chk("mid_add_b", 32'(add_b), 0);
    chk("mid_res_sum", 32'(res_sum), 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h12, 8'h34);
    wait_res("post_rst", 8'h46);

    got_q.delete();
    en0 = en_cnt;
    bad = 0; prev = 0;
    in_a = 8'($urandom_range(255)); in_b = 8'($urandom_range(255)); in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      k = 0;
      while (!in_ready && k < 60) begin @(negedge clk); k++; end
      t = cyc;
      if (k >= 60 || (i > 0 && t - prev != 13)) bad++;
      prev = t;
      exp_q.push_back(8'(in_a + in_b));
      @(negedge clk);
      if (i == 15) in_valid = 1'b0;
      else begin in_a = 8'($urandom_range(255)); in_b = 8'($urandom_range(255)); end
    end
    k = 0;
    while (got_q.size() < 16 && k < 40) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    chk("b2b_spacing", bad, 0);
    chk("b2b_count", got_q.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("b2b_sum%0d", i), i < got_q.size() ? 32'(got_q[i]) : -1, 32'(exp_q[i]));
    chk("b2b_en_pulses", en_cnt - en0, 32);
    chk("en_consecutive", en_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
